tri_timer_ctrl: RTL and testbench
=================================

Name: tri_timer_ctrl

Overview:
Upstream control stage of the APU triangle channel. It holds the triangle register state ($4008/$400A/$400B), runs the 11-bit period timer, the linear counter and the length counter. It emits the one-cycle `next_step` strobe that advances the downstream 32-step triangle sequencer. It also reports length-counter status for the $4015 read.

Parameters:
- MUTE_ULTRASONIC, 0: when 1, `next_step` is suppressed while period < 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_en  input  1  CPU-rate clock enable; all state updates qualified by it
- reg_we  input  1  register write strobe, sampled when cpu_en=1
- reg_addr  input  2  0=$4008, 1=$4009 (ignored), 2=$400A, 3=$400B
- reg_wdata  input  8  write data
- chan_enable  input  1  $4015 bit2 level
- quarter_frame  input  1  frame-sequencer quarter clock, sampled when cpu_en=1
- half_frame  input  1  frame-sequencer half clock, sampled when cpu_en=1
- next_step  output  1  sequencer advance strobe, high only in cpu_en cycles
- length_active  output  1  length counter != 0 (for $4015 read)

Behaviour:
- Reset (sync, high) clears every register to 0: period[10:0], timer[10:0], linear[6:0], lin_reload_val[6:0], control, reload_flag, length[7:0]. Therefore next_step=0 and length_active=0. Reset overrides any same-cycle write or frame clock.
- All sequential updates occur only on clk edges with cpu_en=1. With cpu_en=0 all state holds.
- Register writes:
  - addr0: control<=wdata[7], lin_reload_val<=wdata[6:0].
  - addr2: period[7:0]<=wdata.
  - addr3: period[10:8]<=wdata[2:0] and reload_flag<=1. Also length<=LEN_TABLE[wdata[7:3]], but only if chan_enable=1.
  - Writes never touch timer.
- LEN_TABLE, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Timer (every cpu_en cycle): if timer==0 then timer<=period, else timer<=timer-1. Step rate = f_cpu/(period+1).
- next_step is combinational: cpu_en & (timer==0) & (linear!=0) & (length!=0) & !(MUTE_ULTRASONIC & period<2).
  - It is evaluated from registered state, so the strobe coincides with the reload cycle.
  - Because it is gated by cpu_en, it is exactly one enabled cycle wide.
- Linear counter, on quarter_frame:
  - If reload_flag=1, linear<=lin_reload_val; else if linear!=0, linear<=linear-1.
  - Then, if control=0, reload_flag<=0.
  - An addr3 write in the same cycle wins: reload_flag ends 1.
- Length counter, on half_frame: if length!=0 and control=0, length<=length-1.
  - An addr3 load in the same cycle wins over the decrement.
- chan_enable=0 forces length<=0 every cpu_en cycle, with priority over loads and decrements.
- length_active = (length!=0).
- Wrap rules: timer underflow is impossible, since 0 reloads. Linear and length saturate at 0 and never wrap.
- When quarter_frame and half_frame coincide, both counters update independently in the same cycle.

Test Plan:
1. Reset with cpu_en=1 -> next_step=0 and length_active=0. Timer counts 0 then reloads period=0 every cycle, with no strobe.
2. chan_enable=1; write addr0=0x7F, addr2=0x03, addr3=0x08 (index 1 → length 254); one quarter_frame -> linear=127, length_active=1. next_step pulses every 4 cpu_en cycles; with cpu_en toggling every other clk, the pulse width is 1 clk.
3. addr0=0x05 (control=0), addr3 write, then 6 quarter_frames -> linear goes 5,4,3,2,1,0. next_step stops after linear reaches 0, and reload_flag is clear after the first quarter_frame.
4. control=1 with lin_reload_val=3 -> each quarter_frame reloads linear to 3 and it never reaches 0. half_frame does not decrement length.
5. addr3=0x18 (index 3 → length 2), control=0, two half_frames -> length_active drops after the second. Then an addr3 write in the same cycle as a half_frame leaves the full table value loaded.
6. chan_enable=0 in the same cycle as an addr3 write -> length stays 0. MUTE_ULTRASONIC=1 with period=1 -> no next_step; the same setup with MUTE_ULTRASONIC=0 -> a pulse every 2 cpu_en cycles.

Source files
------------

// File: rtl/tri_timer_ctrl.sv
// Triangle channel control stage: register state, 11-bit period timer,
// linear counter and length counter. Produces the sequencer advance strobe
// and the length-counter status bit for the channel status read.
module tri_timer_ctrl #(
    parameter bit MUTE_ULTRASONIC = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_en,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       chan_enable,
    input  logic       quarter_frame,
    input  logic       half_frame,
    output logic       next_step,
    output logic       length_active
);

    logic [10:0] period;
    logic [10:0] timer;
    logic [6:0]  linear;
    logic [6:0]  lin_reload_val;
    logic        control;
    logic        reload_flag;
    logic [7:0]  length;

    logic        wr_ctrl;
    logic        wr_lo;
    logic        wr_hi;
    logic        ultrasonic;

    // Length load values indexed by the upper five bits of the $400B write.
    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:    val = 8'd10;
            5'd1:    val = 8'd254;
            5'd2:    val = 8'd20;
            5'd3:    val = 8'd2;
            5'd4:    val = 8'd40;
            5'd5:    val = 8'd4;
            5'd6:    val = 8'd80;
            5'd7:    val = 8'd6;
            5'd8:    val = 8'd160;
            5'd9:    val = 8'd8;
            5'd10:   val = 8'd60;
            5'd11:   val = 8'd10;
            5'd12:   val = 8'd14;
            5'd13:   val = 8'd12;
            5'd14:   val = 8'd26;
            5'd15:   val = 8'd14;
            5'd16:   val = 8'd12;
            5'd17:   val = 8'd16;
            5'd18:   val = 8'd24;
            5'd19:   val = 8'd18;
            5'd20:   val = 8'd48;
            5'd21:   val = 8'd20;
            5'd22:   val = 8'd96;
            5'd23:   val = 8'd22;
            5'd24:   val = 8'd192;
            5'd25:   val = 8'd24;
            5'd26:   val = 8'd72;
            5'd27:   val = 8'd26;
            5'd28:   val = 8'd16;
            5'd29:   val = 8'd28;
            5'd30:   val = 8'd32;
            5'd31:   val = 8'd30;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    // Write strobes are only meaningful in enabled CPU cycles.
    assign wr_ctrl = cpu_en && reg_we && (reg_addr == 2'd0);
    assign wr_lo   = cpu_en && reg_we && (reg_addr == 2'd2);
    assign wr_hi   = cpu_en && reg_we && (reg_addr == 2'd3);

    assign ultrasonic = MUTE_ULTRASONIC && (period < 11'd2);

    // Strobe comes from registered state, so it lines up with the timer reload.
    assign next_step = cpu_en && (timer == 11'd0) && (linear != 7'd0) &&
                       (length != 8'd0) && !ultrasonic;

    assign length_active = (length != 8'd0);

    // CPU-visible register fields: control bit, linear reload value, period.
    always_ff @(posedge clk) begin
        if (reset) begin
            control        <= 1'b0;
            lin_reload_val <= 7'd0;
            period         <= 11'd0;
        end else if (wr_ctrl) begin
            control        <= reg_wdata[7];
            lin_reload_val <= reg_wdata[6:0];
        end else if (wr_lo) begin
            period[7:0]    <= reg_wdata;
        end else if (wr_hi) begin
            period[10:8]   <= reg_wdata[2:0];
        end
    end

    // Period timer: reloads on zero, otherwise counts down each enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= 11'd0;
        end else if (cpu_en) begin
            if (timer == 11'd0) begin
                timer <= period;
            end else begin
                timer <= timer - 11'd1;
            end
        end
    end

    // Linear counter: reload from the latched value or count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            linear <= 7'd0;
        end else if (cpu_en && quarter_frame) begin
            if (reload_flag) begin
                linear <= lin_reload_val;
            end else if (linear != 7'd0) begin
                linear <= linear - 7'd1;
            end
        end
    end

    // Reload flag: set by a $400B write, which beats the quarter-frame clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_flag <= 1'b0;
        end else if (wr_hi) begin
            reload_flag <= 1'b1;
        end else if (cpu_en && quarter_frame && !control) begin
            reload_flag <= 1'b0;
        end
    end

    // Length counter: disable forces zero, then table load, then half-frame decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            length <= 8'd0;
        end else if (cpu_en) begin
            if (!chan_enable) begin
                length <= 8'd0;
            end else if (wr_hi) begin
                length <= len_lookup(reg_wdata[7:3]);
            end else if (half_frame && (length != 8'd0) && !control) begin
                length <= length - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tri_timer_ctrl.sv
// Directed bench for tri_timer_ctrl. Two instances share all inputs: one
// without ultrasonic muting and one with it, so both builds are exercised.
module tb_tri_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_en = 1'b0;
    logic       reg_we = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_wdata = 8'd0;
    logic       chan_enable = 1'b0;
    logic       quarter_frame = 1'b0;
    logic       half_frame = 1'b0;
    logic       next_step;
    logic       length_active;
    logic       next_step_m;
    logic       length_active_m;

    int total = 0;
    int bad = 0;
    logic ns_seen;
    logic nsm_seen;
    int cnt;
    int cntm;
    int cnt_off;

    tri_timer_ctrl #(.MUTE_ULTRASONIC(1'b0)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .chan_enable(chan_enable),
        .quarter_frame(quarter_frame), .half_frame(half_frame),
        .next_step(next_step), .length_active(length_active)
    );

    tri_timer_ctrl #(.MUTE_ULTRASONIC(1'b1)) dut_mute (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .chan_enable(chan_enable),
        .quarter_frame(quarter_frame), .half_frame(half_frame),
        .next_step(next_step_m), .length_active(length_active_m)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample the strobes mid-cycle, pass the edge.
    task automatic step(input logic en, input logic we, input logic [1:0] addr,
                        input logic [7:0] wd, input logic qf, input logic hf);
        cpu_en = en;
        reg_we = we;
        reg_addr = addr;
        reg_wdata = wd;
        quarter_frame = qf;
        half_frame = hf;
        #1;
        ns_seen = next_step;
        nsm_seen = next_step_m;
        @(posedge clk);
        #1;
        reg_we = 1'b0;
        quarter_frame = 1'b0;
        half_frame = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] wd);
        step(1'b1, 1'b1, addr, wd, 1'b0, 1'b0);
    endtask

    // Run n enabled idle cycles, counting strobes of both instances.
    task automatic run(input int n);
        cnt = 0;
        cntm = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
            if (ns_seen) cnt++;
            if (nsm_seen) cntm++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] lin_exp [0:5];
        lin_exp[0] = 7'd5; lin_exp[1] = 7'd4; lin_exp[2] = 7'd3;
        lin_exp[3] = 7'd2; lin_exp[4] = 7'd1; lin_exp[5] = 7'd0;

        @(posedge clk);
        #1;
        // 1: reset, including a write that reset must override
        chan_enable = 1'b1;
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        wr(2'd3, 8'h08);
        check_eq("rst_next_step", next_step, 1'b0);
        check_eq("rst_len_active", length_active, 1'b0);
        reset = 1'b0;
        run(4);
        check_eq("p0_no_strobe", cnt, 0);
        check_eq("p0_timer", dut.timer, 0);

        // 2: linear 127, length 254, period 3
        wr(2'd0, 8'h7F);
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h08);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
        check_eq("t2_linear", dut.linear, 127);
        check_eq("t2_len_active", length_active, 1'b1);
        check_eq("t2_length", dut.length, 254);
        run(16);
        check_eq("t2_pulses", cnt, 4);
        check_eq("t2_pulses_mute", cntm, 4);
        cnt = 0;
        cnt_off = 0;
        for (int i = 0; i < 16; i++) begin
            step((i % 2) == 0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
            if (ns_seen && (i % 2) == 0) cnt++;
            if (ns_seen && (i % 2) != 0) cnt_off++;
        end
        check_eq("t2_toggle_pulses", cnt, 2);
        check_eq("t2_pulse_off_en", cnt_off, 0);

        // 3: linear counts 5..0 with control=0
        wr(2'd0, 8'h05);
        wr(2'd3, 8'h08);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
            check_eq($sformatf("t3_linear%0d", i), dut.linear, lin_exp[i]);
            if (i == 0) check_eq("t3_reload_clr", dut.reload_flag, 1'b0);
        end
        run(8);
        check_eq("t3_no_strobe", cnt, 0);

        // 4: control=1 keeps reloading and freezes length
        wr(2'd0, 8'h83);
        wr(2'd3, 8'h08);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
            check_eq($sformatf("t4_linear%0d", i), dut.linear, 3);
        end
        check_eq("t4_reload_kept", dut.reload_flag, 1'b1);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        check_eq("t4_length_held", dut.length, 254);
        run(8);
        check_eq("t4_pulses", cnt, 2);

        // 5: short length, decrement, saturation, load priority
        wr(2'd0, 8'h05);
        wr(2'd3, 8'h18);
        check_eq("t5_length2", dut.length, 2);
        step(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        check_eq("t5_hf_no_en", dut.length, 2);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        check_eq("t5_active_1", length_active, 1'b1);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        check_eq("t5_active_0", length_active, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        check_eq("t5_saturate", dut.length, 0);
        step(1'b1, 1'b1, 2'd3, 8'h08, 1'b0, 1'b1);
        check_eq("t5_load_wins", dut.length, 254);
        wr(2'd3, 8'hF8);
        check_eq("t5_idx31", dut.length, 30);
        wr(2'd3, 8'h00);
        check_eq("t5_idx0", dut.length, 10);

        // 6: disable beats load; ultrasonic muting
        chan_enable = 1'b0;
        wr(2'd3, 8'h08);
        check_eq("t6_disabled_len", length_active, 1'b0);
        chan_enable = 1'b1;
        wr(2'd0, 8'h7F);
        wr(2'd2, 8'h01);
        wr(2'd3, 8'h08);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
        run(8);
        check_eq("t6_p1_pulses", cnt, 4);
        check_eq("t6_p1_muted", cntm, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
